// File: rtl/comp_pkg.sv
// Shared FSM encoding and default sizing for the comparator edge counter.
package comp_pkg;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN_DEF    = 4;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/comp_edge_counter_if.sv
// Measurement request/result bundle between a controller and comp_edge_counter.
interface comp_edge_counter_if
    import comp_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GATE_W = CNT_W
);
    logic              comp_in;
    logic              start;
    logic [GATE_W-1:0] gate_len;
    logic              comp_filt;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              ovf;

    modport master (
        output comp_in, start, gate_len,
        input  comp_filt, busy, done, count, ovf
    );

    modport slave (
        input  comp_in, start, gate_len,
        output comp_filt, busy, done, count, ovf
    );
endinterface

// File: rtl/comp_glitch_filter.sv
// Synchronizer plus run-length glitch filter; din-to-dout latency SYNC_STAGES+FILT_LEN cycles.
// No backpressure: filters continuously every cycle.
module comp_glitch_filter
    import comp_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [3:0]             run_q;
    logic [3:0]             run_d;
    logic                   dout_q;
    logic                   dout_d;
    logic                   samp;

    assign samp = sync_q[SYNC_STAGES-1];

    // A sample equal to the current output restarts the run.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        run_d  = '0;
        dout_d = dout_q;
        if (samp != dout_q) begin
            if (run_q == RUN_LAST) begin
                dout_d = samp;
            end else begin
                run_d = run_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            run_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            run_q  <= run_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
endmodule

// File: rtl/comp_edge_counter.sv
// Counts filtered comparator rising edges over a gate window; result with a done pulse N+1 cycles after start.
// No backpressure: start is accepted only in IDLE and dropped otherwise.
module comp_edge_counter
    import comp_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    // A gate wider than the count lets a long window saturate a narrow counter.
    parameter int GATE_W      = CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              comp_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    output logic              comp_filt,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);
    localparam logic [CNT_W-1:0]  ACC_MAX  = '1;
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

    state_e            state_q;
    state_e            state_d;
    logic              filt_prev_q;
    logic              edge_pulse;
    logic [CNT_W-1:0]  acc_q;
    logic [CNT_W-1:0]  acc_d;
    logic              acc_ovf_q;
    logic              acc_ovf_d;
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] gate_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              busy_q;
    logic              done_q;

    comp_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (comp_in),
        .dout  (comp_filt)
    );

    assign edge_pulse = comp_filt & ~filt_prev_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        gate_d    = gate_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    acc_ovf_d = 1'b0;
                    gate_d    = gate_len;
                    state_d   = (gate_len == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                if (edge_pulse) begin
                    if (acc_q == ACC_MAX) begin
                        acc_ovf_d = 1'b1;
                    end else begin
                        acc_d = acc_q + CNT_W'(1);
                    end
                end
                if (gate_q == GATE_ONE) begin
                    state_d = DONE;
                end else begin
                    gate_d = gate_q - GATE_ONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Result registers load on entry to DONE so count is valid with done.
        if (state_d == DONE) begin
            count_d = acc_d;
            ovf_d   = acc_ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            filt_prev_q <= 1'b0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            gate_q      <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            filt_prev_q <= comp_filt;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            gate_q      <= gate_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            busy_q      <= (state_d == COUNT);
            done_q      <= (state_d == DONE);
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_comp_edge_counter.sv
// Directed bench for comp_edge_counter: default instance plus a narrow-count instance for saturation.
module tb_comp_edge_counter;
    import comp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    comp_edge_counter_if #(.CNT_W(16))             ifc ();
    comp_edge_counter_if #(.CNT_W(4), .GATE_W(8))  ifs ();

    assign ifs.comp_in = ifc.comp_in;

    comp_edge_counter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .comp_in   (ifc.comp_in),
        .start     (ifc.start),
        .gate_len  (ifc.gate_len),
        .comp_filt (ifc.comp_filt),
        .busy      (ifc.busy),
        .done      (ifc.done),
        .count     (ifc.count),
        .ovf       (ifc.ovf)
    );

    comp_edge_counter #(.CNT_W(4), .GATE_W(8)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .comp_in   (ifs.comp_in),
        .start     (ifs.start),
        .gate_len  (ifs.gate_len),
        .comp_filt (ifs.comp_filt),
        .busy      (ifs.busy),
        .done      (ifs.done),
        .count     (ifs.count),
        .ovf       (ifs.ovf)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit sq_en    = 1'b0;
    int sq_half  = 10;
    int sq_ph    = 0;
    int busy_cnt, done_cnt, done_s_cnt;
    bit filt_hi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clock: sample point is #1 after the edge, then the square wave advances.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sq_en) begin
            sq_ph++;
            if (sq_ph >= sq_half) begin
                sq_ph       = 0;
                ifc.comp_in = ~ifc.comp_in;
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic watch(input int n);
        repeat (n) begin
            tick();
            if (ifc.busy)      busy_cnt++;
            if (ifc.done)      done_cnt++;
            if (ifs.done)      done_s_cnt++;
            if (ifc.comp_filt) filt_hi = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        ifc.comp_in  = 1'b0;
        ifc.start    = 1'b0;
        ifc.gate_len = '0;
        ifs.start    = 1'b0;
        ifs.gate_len = '0;
        ticks(3);
        chk("rst_comp_filt", 32'(ifc.comp_filt), 0);
        chk("rst_busy",      32'(ifc.busy),      0);
        chk("rst_done",      32'(ifc.done),      0);
        chk("rst_count",     32'(ifc.count),     0);
        chk("rst_ovf",       32'(ifc.ovf),       0);

        // Clean step after edge 10 shows at comp_filt after edge 16.
        rst_n = 1'b1;
        cyc   = 0;
        ticks(10);
        ifc.comp_in = 1'b1;
        ticks(5);
        chk("step_c15_low", 32'(ifc.comp_filt), 0);
        tick();
        chk("step_c16_high", 32'(ifc.comp_filt), 1);
        ifc.comp_in = 1'b0;
        ticks(10);
        chk("step_fall", 32'(ifc.comp_filt), 0);

        // 3-cycle glitch inside a 30-cycle window.
        busy_cnt = 0; done_cnt = 0; done_s_cnt = 0; filt_hi = 1'b0;
        ifc.start = 1'b1; ifc.gate_len = 16'd30;
        tick();
        ifc.start   = 1'b0;
        ifc.comp_in = 1'b1;
        watch(3);
        ifc.comp_in = 1'b0;
        watch(30);
        chk("glitch_filt_low", 32'(filt_hi), 0);
        chk("glitch_done",     32'(done_cnt), 1);
        chk("glitch_count",    32'(ifc.count), 0);

        // A 4-cycle pulse is just long enough to pass.
        filt_hi = 1'b0;
        ifc.comp_in = 1'b1;
        watch(4);
        ifc.comp_in = 1'b0;
        watch(12);
        chk("pulse4_pass", 32'(filt_hi), 1);
        ticks(10);

        // Period-20 square wave over a 200-cycle window.
        sq_half = 10; sq_ph = 0; sq_en = 1'b1;
        ticks(25);
        busy_cnt = 0; done_cnt = 0;
        ifc.start = 1'b1; ifc.gate_len = 16'd200;
        watch(1);
        ifc.start = 1'b0;
        watch(260);
        chk("sq20_busy_cycles", 32'(busy_cnt),  200);
        chk("sq20_done_pulses", 32'(done_cnt),  1);
        chk("sq20_count",       32'(ifc.count), 10);
        chk("sq20_ovf",         32'(ifc.ovf),   0);

        // Zero-length gate, and a start held into DONE.
        sq_en = 1'b0;
        ifc.start = 1'b1; ifc.gate_len = 16'd0;
        tick();
        chk("g0_done",  32'(ifc.done),  1);
        chk("g0_count", 32'(ifc.count), 0);
        chk("g0_ovf",   32'(ifc.ovf),   0);
        tick();
        chk("start_in_done_ignored", 32'(ifc.done), 0);
        chk("start_in_done_busy",    32'(ifc.busy), 0);
        ifc.start = 1'b0;
        tick();

        // Second start while busy must not restart the window.
        sq_ph = 0; sq_en = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        ifc.start = 1'b1; ifc.gate_len = 16'd20;
        watch(1);
        ifc.start = 1'b0;
        watch(5);
        ifc.start = 1'b1; ifc.gate_len = 16'd3;
        watch(1);
        ifc.start = 1'b0;
        watch(40);
        chk("busy_start_busy_cycles", 32'(busy_cnt),  20);
        chk("busy_start_single_done", 32'(done_cnt),  1);
        chk("busy_start_count",       32'(ifc.count), 1);

        // Period-12 over 240 cycles: 20 edges saturates the 4-bit counter.
        sq_half = 6; sq_ph = 0;
        ticks(20);
        busy_cnt = 0; done_cnt = 0; done_s_cnt = 0;
        ifc.start = 1'b1; ifc.gate_len = 16'd240;
        ifs.start = 1'b1; ifs.gate_len = 8'd240;
        watch(1);
        ifc.start = 1'b0;
        ifs.start = 1'b0;
        watch(260);
        chk("sat_done_pulses", 32'(done_s_cnt), 1);
        chk("sat_count",       32'(ifs.count),  15);
        chk("sat_ovf",         32'(ifs.ovf),    1);
        chk("wide_count",      32'(ifc.count),  20);
        chk("wide_ovf",        32'(ifc.ovf),    0);

        // Next quiet window clears the overflow flag.
        sq_en = 1'b0;
        ifc.comp_in = 1'b0;
        ticks(12);
        ifs.start = 1'b1; ifs.gate_len = 8'd5;
        tick();
        ifs.start = 1'b0;
        ticks(10);
        chk("ovf_cleared",   32'(ifs.ovf),   0);
        chk("count_cleared", 32'(ifs.count), 0);

        // Reset at cycle 50 of a 200-cycle window, with start held on the reset edge.
        sq_half = 10; sq_ph = 0; sq_en = 1'b1;
        ifc.start = 1'b1; ifc.gate_len = 16'd200;
        tick();
        ifc.start = 1'b0;
        ticks(49);
        chk("pre_rst_busy", 32'(ifc.busy), 1);
        rst_n     = 1'b0;
        ifc.start = 1'b1;
        tick();
        rst_n     = 1'b1;
        ifc.start = 1'b0;
        chk("rst_mid_busy",  32'(ifc.busy),  0);
        chk("rst_mid_count", 32'(ifc.count), 0);
        chk("rst_mid_done",  32'(ifc.done),  0);
        busy_cnt = 0; done_cnt = 0;
        watch(250);
        chk("rst_mid_no_done",      32'(done_cnt), 0);
        chk("rst_mid_start_ignored", 32'(busy_cnt), 0);
        ifc.start = 1'b1; ifc.gate_len = 16'd5;
        watch(1);
        ifc.start = 1'b0;
        chk("post_rst_accept", 32'(ifc.busy), 1);
        watch(10);
        chk("post_rst_done", 32'(done_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/comp_edge_counter.md
COMP_EDGE_COUNTER -- requirements
Module: comp_edge_counter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (min 2).
REQ-002 SHALL have parameter FILT_LEN, default 4, consecutive samples needed to accept a level change (1..15).
REQ-003 SHALL have parameter CNT_W, default 16, width of edge count and gate length.
REQ-004 SHALL use port clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL use port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL use port comp_in, input, 1: asynchronous digital output of the analog comparator/inverter stage.
REQ-007 SHALL use port start, input, 1: one-cycle request to begin a measurement.
REQ-008 SHALL use port gate_len, input, CNT_W: measurement window length in clk cycles, sampled on accepted start.
REQ-009 SHALL use port comp_filt, output, 1: synchronized, glitch-filtered comparator level.
REQ-010 SHALL use port busy, output, 1: high while a measurement window is open.
REQ-011 SHALL use port done, output, 1: one-cycle pulse when count becomes valid.
REQ-012 SHALL use port count, output, CNT_W: rising edges counted in the last window, held until next done.
REQ-013 SHALL use port ovf, output, 1: last window saturated count.

Function
REQ-014 SHALL pass comp_in through SYNC_STAGES flops before any other use.
REQ-015 SHALL change comp_filt only after FILT_LEN consecutive synchronized samples differ from the current comp_filt; any matching sample clears the run counter.
REQ-016 SHALL give comp_in-to-comp_filt latency of exactly SYNC_STAGES+FILT_LEN cycles for a clean step.
REQ-017 SHALL generate an internal edge pulse for one cycle on each 0->1 transition of comp_filt; falling edges are not counted.
REQ-018 SHALL implement FSM states IDLE, COUNT, DONE.
REQ-019 SHALL accept start only in IDLE; start in COUNT or DONE is ignored.
REQ-020 SHALL, on accepted start with gate_len=0, go to DONE next cycle with count=0, ovf=0.
REQ-021 SHALL, on accepted start with gate_len=N>0, clear the accumulator, enter COUNT, and keep it for exactly N cycles, then enter DONE.
REQ-022 SHALL count edge pulses occurring in those N COUNT cycles only; an edge in the same cycle as the start acceptance is not counted.
REQ-023 SHALL saturate the accumulator at 2^CNT_W-1 and set the overflow flag on any edge that would exceed it.
REQ-024 SHALL, in DONE, load count and ovf from the accumulator, assert done for that single cycle, and return to IDLE next cycle.
REQ-025 SHALL assert busy exactly while in COUNT.
REQ-026 SHALL keep comp_filt filtering continuously regardless of FSM state.

Reset
REQ-027 SHALL, with rst_n low at a clk edge, clear synchronizer flops, filter run counter, comp_filt, accumulator, gate counter, count, ovf, done, busy, and return FSM to IDLE.
REQ-028 SHALL, on reset during COUNT, discard the window with no done pulse.
REQ-029 SHALL ignore start on the cycle rst_n is low.

Structure
REQ-030 SHALL place the FSM state enum and default CNT_W/FILT_LEN/SYNC_STAGES constants in shared package comp_pkg.
REQ-031 SHALL implement synchronizer plus glitch filter as sub-module comp_glitch_filter (ports clk, rst_n, din, dout).
REQ-032 SHALL contain no combinational path from comp_in to any output.

Verification
REQ-033 SHALL check: comp_in step 0->1 at cycle 10, defaults -> comp_filt rises at cycle 16.
REQ-034 SHALL check: 3-cycle high glitch on comp_in (FILT_LEN=4) -> comp_filt stays 0, count unchanged.
REQ-035 SHALL check: square wave period 20 cycles, gate_len=200, start -> busy 200 cycles, done pulse, count=10, ovf=0.
REQ-036 SHALL check: gate_len=0 start -> done next cycle, count=0; start pulsed again while busy -> ignored, single done.
REQ-037 SHALL check: CNT_W=4, period 12, gate_len=240 -> count=15, ovf=1.
REQ-038 SHALL check: rst_n low at cycle 50 of a 200-cycle window -> busy=0, count=0, no done, FSM IDLE.
